beta_cmp: RTL and testbench
===========================

Name: beta_cmp

Overview:
BETA ALU compare unit. It converts the Z/V/N flags produced by the ALU adder/subtractor (A−B) into a WIDTH-bit boolean result for the CMPEQ, CMPLT and CMPLE instructions. The result is registered and feeds the ALU output mux, with one cycle of latency.

Parameters:
- WIDTH, 32, width of result Y; must be ≥1.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset, synchronous, active-low.
- CFN  input  2  compare function select: 01=EQ, 10=LT, 11=LE, 00=reserved.
- Z  input  1  zero flag of A−B (result==0).
- V  input  1  signed overflow flag of A−B.
- N  input  1  negative flag of A−B (result MSB).
- Y  output  WIDTH  compare result: bit0 = boolean, bits WIDTH-1..1 = 0.

Interface: one clock; reset is synchronous and active-low.

Behaviour:
- Combinational compare bit cmp:
  - CFN=01 (EQ): cmp = Z.
  - CFN=10 (LT): cmp = N XOR V.
  - CFN=11 (LE): cmp = Z OR (N XOR V).
  - CFN=00 (reserved): cmp = 0.
- Register update on every rising CLK edge:
  - RST_N=0: Y <= 0 (all bits).
  - RST_N=1: Y <= {WIDTH-1 zeros, cmp}.
- Latency: exactly 1 cycle. Y reflects the CFN/Z/V/N values sampled at the most recent rising edge, and holds until the next edge.
- Bits Y[WIDTH-1:1] are always 0, including after reset and for every CFN.
- No enable and no handshake: a new result is produced every cycle.
- Reset mid-operation: the pending result is discarded and Y=0 on the edge where RST_N=0. The first valid result appears on the first edge with RST_N=1.
- Changes to inputs between edges do not affect Y (no combinational path from inputs to Y).
- Flag combinations that are physically impossible (e.g. Z=1 with N=1) are still evaluated purely by the equations above; no special casing.
- Power-up value of Y before the first reset is undefined; the bench must apply reset first.

Test Plan:
- Reset: RST_N=0 for 2 edges with CFN=11, Z=1 → Y=0x00000000. Release RST_N, same inputs, next edge → Y=0x00000001.
- EQ sweep: CFN=01, all 8 Z/V/N combos → Y=1 iff Z=1. Examples: Z=0,V=1,N=1 → 0; Z=1,V=0,N=1 → 1.
- LT sweep: CFN=10, all 8 combos → Y=N^V:
  - V=0,N=1 → 1; V=1,N=0 → 1; V=1,N=1 → 0.
  - Z=1,V=0,N=0 → 0; Z=1,V=1,N=0 → 1.
- LE sweep: CFN=11, all 8 combos → Y=Z|(N^V):
  - Z=0,V=1,N=1 → 0; Z=0,V=0,N=1 → 1; Z=1,V=0,N=0 → 1.
- Reserved/latency: CFN=00 with any flags → Y=0. Change inputs mid-cycle → Y unchanged until the next rising edge, then updated with 1-cycle latency.
- Reset mid-stream: Y=1 (CFN=01, Z=1), assert RST_N=0 for one edge → Y=0. Deassert → Y=1 on the following edge. Upper bits checked 0 throughout.

Source files
------------

// File: rtl/beta_cmp.sv
// BETA ALU compare unit: turns the Z/V/N flags of A-B into a registered
// WIDTH-bit boolean for CMPEQ / CMPLT / CMPLE, with one cycle of latency.
module beta_cmp #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [1:0]       CFN,
   input  logic             Z,
   input  logic             V,
   input  logic             N,
   output logic [WIDTH-1:0] Y
);

   typedef enum logic [1:0] {
      CFN_RSV = 2'b00,
      CFN_EQ  = 2'b01,
      CFN_LT  = 2'b10,
      CFN_LE  = 2'b11
   } cfn_e;

   cfn_e cfn;
   logic lt;
   logic cmp_d;
   logic cmp_q;

   assign cfn = cfn_e'(CFN);

   // Signed less-than of A-B: the sign bit is only trustworthy when there was no overflow.
   assign lt = N ^ V;

   // NOTE: give every always_comb output a default first so no path can infer a latch.
   always_comb begin
      cmp_d = 1'b0;
      case (cfn)
         CFN_EQ:  cmp_d = Z;
         CFN_LT:  cmp_d = lt;
         CFN_LE:  cmp_d = Z | lt;
         default: cmp_d = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so all flops update together.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cmp_q <= 1'b0;
      end else begin
         cmp_q <= cmp_d;
      end
   end

   // Only bit 0 carries state; the upper bits are constant zero.
   always_comb begin
      Y    = '0;
      Y[0] = cmp_q;
   end

endmodule

// File: tb/tb_beta_cmp.sv
// Self-checking bench for beta_cmp: a driver pushes hand-computed expected
// results into a scoreboard queue, a monitor pops and compares one cycle later.
module tb_beta_cmp;

   localparam int WIDTH = 32;

   typedef struct {
      string            name;
      logic             rst_n;
      logic [1:0]       cfn;
      logic             z;
      logic             v;
      logic             n;
      logic [WIDTH-1:0] exp;
   } vec_t;

   typedef struct {
      string            name;
      logic [WIDTH-1:0] exp;
   } sb_t;

   logic             CLK;
   logic             RST_N;
   logic [1:0]       CFN;
   logic             Z;
   logic             V;
   logic             N;
   logic [WIDTH-1:0] Y;

   int  n_cmp;
   int  n_fail;
   sb_t sb_q[$];

   beta_cmp #(.WIDTH(WIDTH)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .CFN   (CFN),
      .Z     (Z),
      .V     (V),
      .N     (N),
      .Y     (Y)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: Y=%h expected %h", name, act, exp);
      end
   endtask

   // Drive one vector at the falling edge; its result is due after the next rising edge.
   task automatic apply(input vec_t vec);
      sb_t e;
      @(negedge CLK);
      RST_N = vec.rst_n;
      CFN   = vec.cfn;
      Z     = vec.z;
      V     = vec.v;
      N     = vec.n;
      e.name = vec.name;
      e.exp  = vec.exp;
      sb_q.push_back(e);
   endtask

   // Monitor: the DUT presents a new result every cycle, shortly after the rising edge.
   initial begin
      sb_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, Y, e.exp);
         end
      end
   end

   vec_t vecs[$] = '{
      '{"rst0",      1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0000_0000},
      '{"rst1",      1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0000_0000},
      '{"rst_rel",   1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0000_0001},
      // EQ: Y = Z   (fields are z, v, n)
      '{"eq_000",    1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_0000},
      '{"eq_001",    1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0000_0000},
      '{"eq_010",    1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0000_0000},
      '{"eq_011",    1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 32'h0000_0000},
      '{"eq_100",    1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_0001},
      '{"eq_101",    1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 32'h0000_0001},
      '{"eq_110",    1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0000_0001},
      '{"eq_111",    1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 32'h0000_0001},
      // LT: Y = N ^ V
      '{"lt_000",    1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_0000},
      '{"lt_001",    1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0000_0001},
      '{"lt_010",    1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0000_0001},
      '{"lt_011",    1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0000_0000},
      '{"lt_100",    1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0000_0000},
      '{"lt_101",    1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 32'h0000_0001},
      '{"lt_110",    1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 32'h0000_0001},
      '{"lt_111",    1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 32'h0000_0000},
      // LE: Y = Z | (N ^ V)
      '{"le_000",    1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0000_0000},
      '{"le_001",    1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 32'h0000_0001},
      '{"le_010",    1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0000_0001},
      '{"le_011",    1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 32'h0000_0000},
      '{"le_100",    1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0000_0001},
      '{"le_101",    1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 32'h0000_0001},
      '{"le_110",    1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h0000_0001},
      '{"le_111",    1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 32'h0000_0001},
      // Reserved function always yields 0
      '{"rsv_111",   1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0000},
      '{"rsv_100",   1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_0000},
      '{"rsv_001",   1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0000_0000}
   };

   vec_t mid_vecs[$] = '{
      '{"mid_set",   1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_0001},
      '{"mid_rst",   1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_0000},
      '{"mid_rel",   1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_0001}
   };

   initial begin
      vec_t lt_vec;
      vec_t after_vec;
      int   budget;
      n_cmp  = 0;
      n_fail = 0;
      RST_N  = 1'b0;
      CFN    = 2'b11;
      Z      = 1'b1;
      V      = 1'b0;
      N      = 1'b0;

      foreach (vecs[i]) apply(vecs[i]);

      // Latency: result must hold while inputs change between edges.
      lt_vec = '{"lat_set", 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0000_0001};
      apply(lt_vec);
      @(posedge CLK);
      #3;
      CFN = 2'b01;
      Z   = 1'b0;
      #1;
      check("lat_hold", Y, 32'h0000_0001);
      after_vec = '{"lat_upd", 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
      apply(after_vec);

      foreach (mid_vecs[i]) apply(mid_vecs[i]);

      budget = 0;
      while (sb_q.size() > 0 && budget < 10) begin
         @(posedge CLK);
         budget++;
      end
      #2;
      if (sb_q.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
